// File: rtl/int_requester_pkg.sv
// Shared constants for the interrupt requester and its controller:
// FSM encoding, source count and the inta/intb group split.
package int_requester_pkg;

  localparam int NUM_SRC     = 8;
  localparam int SRC_W       = 3;
  localparam int GROUP_SPLIT = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  // Sources at or above the split are requested on intb, the rest on inta.
  function automatic logic is_group_b(input logic [SRC_W-1:0] id);
    return id >= SRC_W'(GROUP_SPLIT);
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the unmasked pending vector.
module int_prio_enc
  import int_requester_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_vec,
  output logic [SRC_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (i_vec[k]) begin
        o_idx   = SRC_W'(k);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_requester.sv
// Interrupt requester: captures peripheral irq edges into a pending
// register, arbitrates unmasked sources and drives one outstanding
// request at a time towards the controller's inta/intb inputs.
module int_requester
  import int_requester_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_SRC-1:0] i_irq,
  input  logic [15:0]        i_data_bus,
  input  logic               i_mask_we,
  input  logic               i_int_ack,
  input  logic               i_recovery,
  output logic               o_inta,
  output logic               o_intb,
  output logic [SRC_W-1:0]   o_src_id,
  output logic               o_src_valid,
  output logic [NUM_SRC-1:0] o_pending,
  output logic [NUM_SRC-1:0] o_mask
);

  localparam logic [3:0] CNT_LAST = 4'(ACK_TIMEOUT - 1);

  logic [1:0]         state;
  logic [3:0]         cnt;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] avail;
  logic [NUM_SRC-1:0] clr;
  logic [SRC_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               unused_bus_hi;

  assign unused_bus_hi = ^i_data_bus[15:8];

  assign rise  = i_irq & ~irq_q;
  assign avail = pending & ~mask;

  assign o_pending = pending;
  assign o_mask    = mask;

  int_prio_enc u_prio (
    .i_vec   (avail),
    .o_idx   (sel_idx),
    .o_valid (sel_valid)
  );

  // An acknowledged request clears exactly the latched source's pending bit.
  always_comb begin
    clr = '0;
    if (state == ST_REQ && i_int_ack)
      clr[o_src_id] = 1'b1;
  end

  // Irq history, used to detect low-to-high transitions only.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) irq_q <= '0;
    else        irq_q <= i_irq;
  end

  // Pending capture; a new edge in the clearing cycle keeps the bit set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pending <= '0;
    else        pending <= (pending & ~clr) | rise;
  end

  // Mask register, loaded from the low byte of the CPU bus.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)         mask <= '0;
    else if (i_mask_we) mask <= i_data_bus[NUM_SRC-1:0];
  end

  // Request FSM with registered request lines, source id and valid flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      o_inta      <= 1'b0;
      o_intb      <= 1'b0;
      o_src_id    <= '0;
      o_src_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            state    <= ST_REQ;
            cnt      <= '0;
            o_src_id <= sel_idx;
            o_inta   <= !is_group_b(sel_idx);
            o_intb   <= is_group_b(sel_idx);
          end
        end
        ST_REQ: begin
          if (i_int_ack) begin
            state       <= ST_SERVICE;
            cnt         <= '0;
            o_inta      <= 1'b0;
            o_intb      <= 1'b0;
            o_src_valid <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state  <= ST_GAP;
            cnt    <= '0;
            o_inta <= 1'b0;
            o_intb <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_SERVICE: begin
          if (i_recovery) begin
            state       <= ST_GAP;
            o_src_valid <= 1'b0;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_requester.sv
// Bench for int_requester: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural model.
module tb_int_requester;

  localparam int TO = 15;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SVC  = 2;
  localparam int P_GAP  = 3;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [7:0]  irq;
  logic [15:0] data_bus;
  logic        mask_we, int_ack, recovery;
  logic        inta, intb, src_valid;
  logic [2:0]  src_id;
  logic [7:0]  pending, mask;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pend, m_mask, m_prev;
  logic [2:0] m_id;
  int         m_phase, m_waited;

  int_requester #(.ACK_TIMEOUT(TO)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_irq       (irq),
    .i_data_bus  (data_bus),
    .i_mask_we   (mask_we),
    .i_int_ack   (int_ack),
    .i_recovery  (recovery),
    .o_inta      (inta),
    .o_intb      (intb),
    .o_src_id    (src_id),
    .o_src_valid (src_valid),
    .o_pending   (pending),
    .o_mask      (mask)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelReset();
    m_pend   = '0;
    m_mask   = '0;
    m_prev   = '0;
    m_id     = '0;
    m_phase  = P_IDLE;
    m_waited = 0;
  endfunction

  // One clock edge of the requester's rules, using the pre-edge inputs.
  function automatic void modelStep();
    logic [7:0] rise, avail, clr;
    rise   = irq & ~m_prev;
    m_prev = irq;
    clr    = '0;
    case (m_phase)
      P_IDLE: begin
        avail = m_pend & ~m_mask;
        if (avail != 0) begin
          for (int k = 7; k >= 0; k--)
            if (avail[k]) m_id = 3'(k);
          m_phase  = P_REQ;
          m_waited = 0;
        end
      end
      P_REQ: begin
        if (int_ack) begin
          clr[m_id] = 1'b1;
          m_phase   = P_SVC;
        end else begin
          m_waited++;
          if (m_waited >= TO) m_phase = P_GAP;
        end
      end
      P_SVC: if (recovery) m_phase = P_GAP;
      default: m_phase = P_IDLE;
    endcase
    m_pend = (m_pend & ~clr) | rise;
    if (mask_we) m_mask = data_bus[7:0];
  endfunction

  task automatic compareAll();
    checkOutput("inta",      16'(inta),      16'(m_phase == P_REQ && m_id < 4));
    checkOutput("intb",      16'(intb),      16'(m_phase == P_REQ && m_id >= 4));
    checkOutput("src_valid", 16'(src_valid), 16'(m_phase == P_SVC));
    checkOutput("src_id",    16'(src_id),    16'(m_id));
    checkOutput("pending",   16'(pending),   16'(m_pend));
    checkOutput("mask",      16'(mask),      16'(m_mask));
  endtask

  task automatic tick();
    @(posedge clk);
    if (n_rst) modelStep();
    #1;
    compareAll();
  endtask

  // Assert reset mid-cycle; outputs must drop without waiting for a clock.
  task automatic doReset();
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    checkOutput("rst_inta",    16'(inta),      16'd0);
    checkOutput("rst_intb",    16'(intb),      16'd0);
    checkOutput("rst_valid",   16'(src_valid), 16'd0);
    checkOutput("rst_src_id",  16'(src_id),    16'd0);
    checkOutput("rst_pending", 16'(pending),   16'd0);
    checkOutput("rst_mask",    16'(mask),      16'd0);
    modelReset();
    tick();
    tick();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic finishService();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    recovery = 1'b1; tick(); recovery = 1'b0;
    tick();
    tick();
  endtask

  task automatic applyStimulus();
    logic [7:0] flip;
    flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
    irq      = irq ^ flip;
    mask_we  = ($urandom_range(0, 19) == 0);
    data_bus = 16'($urandom);
    int_ack  = ($urandom_range(0, 9) < 3);
    recovery = ($urandom_range(0, 9) < 2);
  endtask

  initial begin
    int n;
    n_rst    = 1'b0;
    irq      = '0;
    data_bus = '0;
    mask_we  = 1'b0;
    int_ack  = 1'b0;
    recovery = 1'b0;
    modelReset();
    #12;
    compareAll();
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Single pulse on source 2, acknowledged on the first request cycle.
    irq = 8'h04; tick(); irq = 8'h00; tick();
    checkOutput("t1_inta", 16'(inta), 16'd1);
    checkOutput("t1_id",   16'(src_id), 16'd2);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checkOutput("t1_inta_low", 16'(inta), 16'd0);
    checkOutput("t1_pend", 16'(pending), 16'h00);
    tick(); tick();
    checkOutput("t1_valid", 16'(src_valid), 16'd1);
    recovery = 1'b1; tick(); recovery = 1'b0;
    checkOutput("t1_gap_valid", 16'(src_valid), 16'd0);
    tick();

    // Simultaneous edges on 5 and 1: lowest index first, then 5 on intb.
    irq = 8'h22; tick(); irq = 8'h00; tick();
    checkOutput("t2_id1", 16'(src_id), 16'd1);
    checkOutput("t2_inta", 16'(inta), 16'd1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    recovery = 1'b1; tick(); recovery = 1'b0;
    tick(); tick();
    checkOutput("t2_id5", 16'(src_id), 16'd5);
    checkOutput("t2_intb", 16'(intb), 16'd1);
    finishService();

    // Masked source stays pending until the mask is lifted.
    mask_we = 1'b1; data_bus = 16'h0008; tick(); mask_we = 1'b0;
    irq = 8'h08; tick(); irq = 8'h00; tick(); tick(); tick();
    checkOutput("t3_pend", 16'(pending), 16'h08);
    checkOutput("t3_noreq", 16'(inta), 16'd0);
    mask_we = 1'b1; data_bus = 16'h0000; tick(); mask_we = 1'b0;
    tick();
    checkOutput("t3_inta", 16'(inta), 16'd1);
    checkOutput("t3_id", 16'(src_id), 16'd3);
    finishService();

    // Unacknowledged source 6 times out, drops the line, then retries.
    irq = 8'h40; tick(); irq = 8'h00; tick();
    n = 0;
    while (intb && n < 40) begin n++; tick(); end
    checkOutput("t4_high_cycles", 16'(n), 16'(TO));
    n = 0;
    while (!intb && n < 10) begin n++; tick(); end
    checkOutput("t4_low_seen", 16'(n != 0), 16'd1);
    checkOutput("t4_reassert", 16'(intb), 16'd1);
    checkOutput("t4_pend6", 16'(pending[6]), 16'd1);
    finishService();

    // Reset while servicing source 4; no request until a fresh edge.
    irq = 8'h10; tick(); irq = 8'h00; tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tick();
    checkOutput("t5_valid", 16'(src_valid), 16'd1);
    checkOutput("t5_id", 16'(src_id), 16'd4);
    doReset();
    tick(); tick(); tick();
    checkOutput("t5_norq", 16'(intb), 16'd0);
    irq = 8'h10; tick(); irq = 8'h00; tick();
    checkOutput("t5_intb", 16'(intb), 16'd1);
    finishService();

    // Re-edge on source 0 in its own ack cycle keeps it pending.
    irq = 8'h01; tick(); irq = 8'h00; tick();
    int_ack = 1'b1; irq = 8'h01; tick(); int_ack = 1'b0; irq = 8'h00;
    checkOutput("t6_pend0", 16'(pending[0]), 16'd1);
    recovery = 1'b1; tick(); recovery = 1'b0;
    tick(); tick();
    checkOutput("t6_inta", 16'(inta), 16'd1);
    checkOutput("t6_id", 16'(src_id), 16'd0);
    finishService();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus();
      if ($urandom_range(0, 299) == 0) doReset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
